// File: rtl/debug_sba.sv
// System Bus Access manager: owns sbcs/sbaddress0/sbdata0 and runs single 32-bit bus transfers.
// Optional bus timeout is enabled with `define DEBUG_SBA_TIMEOUT_EN.
module debug_sba #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dmi_req_valid,
  input  logic [7:0]        dmi_req_addr,
  input  logic              dmi_req_write,
  input  logic [31:0]       dmi_req_wdata,
  output logic              dmi_resp_valid,
  output logic [31:0]       dmi_resp_rdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_be,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_err
);

  localparam logic [7:0] AddrSbcs    = 8'h38;
  localparam logic [7:0] AddrSbaddr0 = 8'h39;
  localparam logic [7:0] AddrSbdata0 = 8'h3c;

  localparam logic [2:0] SbeNone    = 3'd0;
  localparam logic [2:0] SbeTimeout = 3'd1;
  localparam logic [2:0] SbeBadaddr = 3'd2;
  localparam logic [2:0] SbeAlign   = 3'd3;
  localparam logic [2:0] SbeSize    = 3'd4;

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] sbaddr_q, sbaddr_d;
  logic [31:0]       sbdata_q, sbdata_d;
  logic              readonaddr_q, readonaddr_d, readondata_q, readondata_d;
  logic              autoinc_q, autoinc_d, busyerror_q, busyerror_d;
  logic [2:0]        access_q, access_d, error_q, error_d;
  logic [2:0]        tx_access_q, tx_access_d;
  logic              tx_autoinc_q, tx_autoinc_d, tx_we_q, tx_we_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;

  logic        busy, inhibit, req_sbcs_wr, req_addr_wr, req_data_wr, req_data_rd;
  logic        start, start_we, start_ok, done, timeout;
  logic [1:0]  start_lsb;
  logic [2:0]  start_err;
  logic [31:0] rd_shift;

  always_comb begin : decode
    busy        = (state_q != StIdle);
    inhibit     = busyerror_q | (error_q != SbeNone);
    req_sbcs_wr = dmi_req_valid & dmi_req_write & (dmi_req_addr == AddrSbcs);
    req_addr_wr = dmi_req_valid & dmi_req_write & (dmi_req_addr == AddrSbaddr0);
    req_data_wr = dmi_req_valid & dmi_req_write & (dmi_req_addr == AddrSbdata0);
    req_data_rd = dmi_req_valid & ~dmi_req_write & (dmi_req_addr == AddrSbdata0);
    start       = 1'b0;
    start_we    = 1'b0;
    start_lsb   = sbaddr_q[1:0];
    if (!busy && !inhibit) begin
      if (req_addr_wr && readonaddr_q) begin
        start     = 1'b1;
        start_lsb = dmi_req_wdata[1:0];
      end else if (req_data_wr) begin
        start    = 1'b1;
        start_we = 1'b1;
      end else if (req_data_rd && readondata_q) begin
        start = 1'b1;
      end
    end
    start_err = SbeNone;
    if (access_q > 3'd2) begin
      start_err = SbeSize;
    end else if ((access_q == 3'd1 && start_lsb[0]) || (access_q == 3'd2 && start_lsb != 2'd0)) begin
      start_err = SbeAlign;
    end
    start_ok = start && (start_err == SbeNone);
    done     = (state_q == StWait) && bus_rvalid;
  end

`ifdef DEBUG_SBA_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;

  // Counts every cycle spent in REQ or WAIT; restarts from zero on entry to REQ.
  always_comb begin
    cnt_d   = busy ? cnt_q + 1'b1 : '0;
    timeout = busy && (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) && !done;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin : fsm_next
    state_d = state_q;
    case (state_q)
      StIdle:  if (start_ok)   state_d = StReq;
      StReq:   if (bus_gnt)    state_d = StWait;
      StWait:  if (bus_rvalid) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (timeout) state_d = StIdle;
  end

  always_comb begin : fsm_out
    bus_req   = (state_q == StReq);
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    bus_be    = '0;
    if (state_q == StReq) begin
      bus_we   = tx_we_q;
      bus_addr = sbaddr_q;
      case (tx_access_q)
        3'd0: begin
          bus_be    = 4'b0001 << sbaddr_q[1:0];
          bus_wdata = tx_we_q ? {4{sbdata_q[7:0]}} : '0;
        end
        3'd1: begin
          bus_be    = 4'b0011 << sbaddr_q[1:0];
          bus_wdata = tx_we_q ? {2{sbdata_q[15:0]}} : '0;
        end
        default: begin
          bus_be    = 4'b1111;
          bus_wdata = tx_we_q ? sbdata_q : '0;
        end
      endcase
    end
  end

  always_comb begin : datapath
    sbaddr_d     = sbaddr_q;
    sbdata_d     = sbdata_q;
    readonaddr_d = readonaddr_q;
    readondata_d = readondata_q;
    autoinc_d    = autoinc_q;
    access_d     = access_q;
    busyerror_d  = busyerror_q;
    error_d      = error_q;
    tx_access_d  = tx_access_q;
    tx_autoinc_d = tx_autoinc_q;
    tx_we_d      = tx_we_q;
    resp_valid_d = dmi_req_valid;
    resp_rdata_d = '0;
    rd_shift     = bus_rdata >> {sbaddr_q[1:0], 3'b000};

    if (dmi_req_valid && !dmi_req_write) begin
      case (dmi_req_addr)
        AddrSbcs:    resp_rdata_d = {3'd1, 6'd0, busyerror_q, busy, readonaddr_q, access_q,
                                     autoinc_q, readondata_q, error_q, 7'd32, 2'd0, 3'b111};
        AddrSbaddr0: resp_rdata_d = 32'(sbaddr_q);
        AddrSbdata0: resp_rdata_d = sbdata_q;
        default:     resp_rdata_d = '0;
      endcase
    end

    if (req_sbcs_wr) begin
      readonaddr_d = dmi_req_wdata[20];
      access_d     = dmi_req_wdata[19:17];
      autoinc_d    = dmi_req_wdata[16];
      readondata_d = dmi_req_wdata[15];
      if (dmi_req_wdata[22]) busyerror_d = 1'b0;
      error_d = error_q & ~dmi_req_wdata[14:12];
    end

    if (busy && (req_addr_wr || req_data_wr || req_data_rd)) begin
      busyerror_d = 1'b1;
    end else if (!busy) begin
      if (req_addr_wr) sbaddr_d = ADDR_W'(dmi_req_wdata);
      if (req_data_wr) sbdata_d = dmi_req_wdata;
    end

    if (start && !start_ok) error_d = start_err;
    if (start_ok) begin
      tx_access_d  = access_q;
      tx_autoinc_d = autoinc_q;
      tx_we_d      = start_we;
    end

    if (done) begin
      if (bus_err) begin
        error_d = SbeBadaddr;
      end else begin
        if (!tx_we_q) begin
          case (tx_access_q)
            3'd0:    sbdata_d = {24'd0, rd_shift[7:0]};
            3'd1:    sbdata_d = {16'd0, rd_shift[15:0]};
            default: sbdata_d = rd_shift;
          endcase
        end
        if (tx_autoinc_q) sbaddr_d = sbaddr_q + ADDR_W'(32'd1 << tx_access_q);
      end
    end
    if (timeout) error_d = SbeTimeout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sbaddr_q     <= '0;
      sbdata_q     <= '0;
      readonaddr_q <= 1'b0;
      readondata_q <= 1'b0;
      autoinc_q    <= 1'b0;
      access_q     <= 3'd0;
      busyerror_q  <= 1'b0;
      error_q      <= SbeNone;
      tx_access_q  <= 3'd0;
      tx_autoinc_q <= 1'b0;
      tx_we_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      sbaddr_q     <= sbaddr_d;
      sbdata_q     <= sbdata_d;
      readonaddr_q <= readonaddr_d;
      readondata_q <= readondata_d;
      autoinc_q    <= autoinc_d;
      access_q     <= access_d;
      busyerror_q  <= busyerror_d;
      error_q      <= error_d;
      tx_access_q  <= tx_access_d;
      tx_autoinc_q <= tx_autoinc_d;
      tx_we_q      <= tx_we_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign dmi_resp_valid = resp_valid_q;
  assign dmi_resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_debug_sba.sv
// Directed bench for debug_sba: register-access vector table plus busy, timeout and reset sequences.
module tb_debug_sba;

  logic        clk, rst;
  logic        dmi_req_valid, dmi_req_write;
  logic [7:0]  dmi_req_addr;
  logic [31:0] dmi_req_wdata;
  logic        dmi_resp_valid;
  logic [31:0] dmi_resp_rdata;
  logic        bus_req, bus_we, bus_gnt, bus_rvalid, bus_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

`ifdef DEBUG_SBA_TIMEOUT_EN
  localparam int unsigned Tmo = 16;
`else
  localparam int unsigned Tmo = 256;
`endif

  debug_sba #(.ADDR_W(32), .TIMEOUT_CYCLES(Tmo)) dut (
    .clk            (clk),
    .rst            (rst),
    .dmi_req_valid  (dmi_req_valid),
    .dmi_req_addr   (dmi_req_addr),
    .dmi_req_write  (dmi_req_write),
    .dmi_req_wdata  (dmi_req_wdata),
    .dmi_resp_valid (dmi_resp_valid),
    .dmi_resp_rdata (dmi_resp_rdata),
    .bus_req        (bus_req),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_be         (bus_be),
    .bus_gnt        (bus_gnt),
    .bus_rvalid     (bus_rvalid),
    .bus_rdata      (bus_rdata),
    .bus_err        (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Bus responder: grant at the first negedge req is seen (unless held), rvalid 3 cycles later.
  bit          hold_gnt = 1'b0;
  logic [31:0] resp_data = '0;
  bit          resp_err = 1'b0;
  int          req_cnt = 0;
  logic        cap_we;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;

  initial begin
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = '0;
    bus_err    = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_req) begin
        req_cnt++;
        cap_we    = bus_we;
        cap_addr  = bus_addr;
        cap_wdata = bus_wdata;
        cap_be    = bus_be;
        while (hold_gnt) @(negedge clk);
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        repeat (2) @(negedge clk);
        bus_rvalid = 1'b1;
        bus_rdata  = resp_data;
        bus_err    = resp_err;
        @(negedge clk);
        bus_rvalid = 1'b0;
        bus_err    = 1'b0;
      end
    end
  end

  task automatic dmi_op(input bit wr, input logic [7:0] a, input logic [31:0] d,
                        output logic [31:0] rd);
    @(posedge clk);
    #1;
    dmi_req_valid = 1'b1;
    dmi_req_write = wr;
    dmi_req_addr  = a;
    dmi_req_wdata = d;
    @(posedge clk);
    #1;
    dmi_req_valid = 1'b0;
    dmi_req_write = 1'b0;
    dmi_req_addr  = '0;
    dmi_req_wdata = '0;
    check($sformatf("resp_valid_%02h", a), dmi_resp_valid, 1);
    rd = dmi_resp_rdata;
  endtask

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_bus;
    bit          exp_we;
    logic [31:0] exp_baddr;
    logic [3:0]  exp_be;
    logic [31:0] exp_bwdata;
    logic [31:0] rsp_data;
    bit          rsp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit wr, logic [7:0] a, logic [31:0] d, logic [31:0] e, bit b,
                              bit we, logic [31:0] ba, logic [3:0] be, logic [31:0] bw,
                              logic [31:0] rsp, bit err);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = d; v.exp_rdata = e; v.exp_bus = b; v.exp_we = we;
    v.exp_baddr = ba; v.exp_be = be; v.exp_bwdata = bw; v.rsp_data = rsp; v.rsp_err = err;
    return v;
  endfunction

  function automatic vec_t R(logic [7:0] a, logic [31:0] e);
    return mk(0, a, 0, e, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic vec_t W(logic [7:0] a, logic [31:0] d);
    return mk(1, a, d, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic vec_t WB(logic [7:0] a, logic [31:0] d, logic [31:0] ba, logic [3:0] be,
                              logic [31:0] bw);
    return mk(1, a, d, 0, 1, 1, ba, be, bw, 0, 0);
  endfunction
  function automatic vec_t WR(logic [7:0] a, logic [31:0] d, logic [31:0] ba, logic [3:0] be,
                              logic [31:0] rsp, bit err);
    return mk(1, a, d, 0, 1, 0, ba, be, 0, rsp, err);
  endfunction
  function automatic vec_t RB(logic [7:0] a, logic [31:0] e, logic [31:0] ba, logic [3:0] be,
                              logic [31:0] rsp);
    return mk(0, a, 0, e, 1, 0, ba, be, 0, rsp, 0);
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int          cnt0;
    int          hi;
    rst           = 1'b1;
    dmi_req_valid = 1'b0;
    dmi_req_write = 1'b0;
    dmi_req_addr  = '0;
    dmi_req_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_ctrl", {bus_req, bus_we, bus_be, dmi_resp_valid}, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_wdata", bus_wdata, 0);
    check("rst_rdata", dmi_resp_rdata, 0);
    rst = 1'b0;

    // Byte-address reads and writes, autoincrement, read-on-data, error paths.
    vecs.push_back(R(8'h38, 32'h20000407));
    vecs.push_back(R(8'h39, 32'h0));
    vecs.push_back(R(8'h3c, 32'h0));
    vecs.push_back(R(8'h10, 32'h0));
    vecs.push_back(W(8'h38, 32'h00140000));
    vecs.push_back(R(8'h38, 32'h20140407));
    vecs.push_back(WR(8'h39, 32'h1000, 32'h1000, 4'hf, 32'hDEADBEEF, 0));
    vecs.push_back(R(8'h3c, 32'hDEADBEEF));
    vecs.push_back(R(8'h38, 32'h20140407));
    vecs.push_back(W(8'h38, 32'h00010000));
    vecs.push_back(W(8'h39, 32'h2001));
    vecs.push_back(WB(8'h3c, 32'h000000A5, 32'h2001, 4'b0010, 32'hA5A5A5A5));
    vecs.push_back(R(8'h39, 32'h2002));
    vecs.push_back(W(8'h38, 32'h00130000));
    vecs.push_back(WR(8'h39, 32'h2002, 32'h2002, 4'b1100, 32'h12345678, 0));
    vecs.push_back(R(8'h3c, 32'h00001234));
    vecs.push_back(R(8'h39, 32'h2004));
    vecs.push_back(W(8'h38, 32'h00048000));
    vecs.push_back(RB(8'h3c, 32'h00001234, 32'h2004, 4'hf, 32'hCAFEF00D));
    vecs.push_back(RB(8'h3c, 32'hCAFEF00D, 32'h2004, 4'hf, 32'h11111111));
    vecs.push_back(W(8'h38, 32'h0));
    vecs.push_back(R(8'h3c, 32'h11111111));
    vecs.push_back(W(8'h38, 32'h00020000));
    vecs.push_back(W(8'h39, 32'h3001));
    vecs.push_back(W(8'h3c, 32'h55));
    vecs.push_back(R(8'h38, 32'h20023407));
    vecs.push_back(W(8'h3c, 32'h66));
    vecs.push_back(R(8'h3c, 32'h66));
    vecs.push_back(W(8'h38, 32'h00027000));
    vecs.push_back(R(8'h38, 32'h20020407));
    vecs.push_back(W(8'h38, 32'h000A0000));
    vecs.push_back(W(8'h3c, 32'h1));
    vecs.push_back(R(8'h38, 32'h200A4407));
    vecs.push_back(W(8'h38, 32'h00047000));
    vecs.push_back(R(8'h38, 32'h20040407));
    vecs.push_back(W(8'h38, 32'h00150000));
    vecs.push_back(WR(8'h39, 32'h4000, 32'h4000, 4'hf, 32'hBAD0BAD0, 1));
    vecs.push_back(R(8'h3c, 32'h1));
    vecs.push_back(R(8'h39, 32'h4000));
    vecs.push_back(R(8'h38, 32'h20152407));
    vecs.push_back(W(8'h38, 32'h00007000));
    vecs.push_back(R(8'h38, 32'h20000407));

    foreach (vecs[i]) begin
      resp_data = vecs[i].rsp_data;
      resp_err  = vecs[i].rsp_err;
      cnt0      = req_cnt;
      dmi_op(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      repeat (8) @(negedge clk);
      check($sformatf("v%0d_nreq", i), req_cnt - cnt0, vecs[i].exp_bus);
      if (vecs[i].exp_bus) begin
        check($sformatf("v%0d_we", i), cap_we, vecs[i].exp_we);
        check($sformatf("v%0d_baddr", i), cap_addr, vecs[i].exp_baddr);
        check($sformatf("v%0d_be", i), cap_be, vecs[i].exp_be);
        check($sformatf("v%0d_bwdata", i), cap_wdata, vecs[i].exp_bwdata);
      end
    end

    // Busy error: accesses while the grant is held off.
    hold_gnt = 1'b1;
    dmi_op(1, 8'h38, 32'h00040000, rd);
    dmi_op(1, 8'h39, 32'h5000, rd);
    dmi_op(1, 8'h3c, 32'h11223344, rd);
    @(negedge clk);
    check("busy_req", bus_req, 1);
    check("busy_wdata", bus_wdata, 32'h11223344);
    check("busy_addr", bus_addr, 32'h5000);
    dmi_op(1, 8'h3c, 32'h99999999, rd);
    dmi_op(0, 8'h3c, 0, rd);
    check("busy_stale", rd, 32'h11223344);
    dmi_op(0, 8'h38, 0, rd);
    check("busy_sbcs", rd, 32'h20640407);
    check("busy_hold", {bus_req, bus_be}, {1'b1, 4'hf});
    hold_gnt = 1'b0;
    repeat (8) @(negedge clk);
    check("busy_done", bus_req, 0);
    dmi_op(0, 8'h3c, 0, rd);
    check("busy_sbdata", rd, 32'h11223344);
    dmi_op(0, 8'h38, 0, rd);
    check("busy_err_set", rd, 32'h20440407);
    dmi_op(1, 8'h38, 32'h00440000, rd);
    dmi_op(0, 8'h38, 0, rd);
    check("busy_err_clr", rd, 32'h20040407);

`ifdef DEBUG_SBA_TIMEOUT_EN
    hold_gnt  = 1'b1;
    resp_data = 32'h77777777;
    dmi_op(1, 8'h3c, 32'h1, rd);
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_req) hi++;
    end
    check("tmo_req_cycles", hi, Tmo);
    hold_gnt = 1'b0;
    repeat (8) @(negedge clk);
    dmi_op(0, 8'h38, 0, rd);
    check("tmo_sbcs", rd, 32'h20041407);
    dmi_op(0, 8'h3c, 0, rd);
    check("tmo_sbdata", rd, 32'h1);
    dmi_op(1, 8'h38, 32'h00047000, rd);
`endif

    // Reset while REQ is pending; the late response must be ignored.
    hold_gnt = 1'b1;
    dmi_op(1, 8'h3c, 32'hABCD0000, rd);
    @(negedge clk);
    check("mid_req", bus_req, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_ctrl", {bus_req, bus_we, bus_be, dmi_resp_valid}, 0);
    check("mid_rst_addr", bus_addr, 0);
    check("mid_rst_wdata", bus_wdata, 0);
    @(negedge clk);
    rst       = 1'b0;
    resp_data = 32'hFFFFFFFF;
    hold_gnt  = 1'b0;
    repeat (8) @(negedge clk);
    check("post_rst_req", bus_req, 0);
    dmi_op(0, 8'h38, 0, rd);
    check("post_rst_sbcs", rd, 32'h20000407);
    dmi_op(0, 8'h3c, 0, rd);
    check("post_rst_sbdata", rd, 0);
    dmi_op(0, 8'h39, 0, rd);
    check("post_rst_sbaddr", rd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
